// File: rtl/pc_pkg.sv
// Shared fetch-PC types and constants for the redirect unit.
package pc_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned PC_STEP = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned PERF_W  = 8;

  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/redirect_arbiter.sv
// Picks the redirect target from the two EX slots; slot 1 is older and wins.
module redirect_arbiter
  import pc_pkg::*;
(
  input  logic            ex_valid1_i,
  input  logic            ex_valid2_i,
  input  logic            br1_taken_i,
  input  logic            br2_taken_i,
  input  logic [PC_W-1:0] br1_target_i,
  input  logic [PC_W-1:0] br2_target_i,
  output logic            redir,
  output logic [PC_W-1:0] target,
  output logic            kill_slot2
);

  logic t1;
  logic t2;

  // Qualify taken flags with slot validity and arbitrate by age.
  always_comb begin
    t1         = ex_valid1_i & br1_taken_i;
    t2         = ex_valid2_i & br2_taken_i;
    redir      = t1 | t2;
    target     = br2_target_i;
    kill_slot2 = 1'b0;
    if (t1) begin
      target     = br1_target_i;
      kill_slot2 = 1'b1;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Owns the fetch PC, sequences the post-redirect refill bubble and
// drives pipeline flush/kill controls from EX-stage branch resolution.
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              ex_valid1_i,
  input  logic              ex_valid2_i,
  input  logic              br1_taken_i,
  input  logic              br2_taken_i,
  input  logic [PC_W-1:0]   br1_target_i,
  input  logic [PC_W-1:0]   br2_target_i,
  output logic [PC_W-1:0]   fetch_pc_o,
  output logic              fetch_valid_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              kill_slot2_o,
  output logic [PERF_W-1:0] redirect_cnt_o
);

  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [PERF_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;
  logic             redir;
  logic [PC_W-1:0]  target;
  logic             kill_slot2;

  redirect_arbiter u_arb (
    .ex_valid1_i  (ex_valid1_i),
    .ex_valid2_i  (ex_valid2_i),
    .br1_taken_i  (br1_taken_i),
    .br2_taken_i  (br2_taken_i),
    .br1_target_i (br1_target_i),
    .br2_target_i (br2_target_i),
    .redir        (redir),
    .target       (target),
    .kill_slot2   (kill_slot2)
  );

  // Same-cycle squash controls, forced quiet while reset is held.
  assign flush_idex_o  = rst_n & redir;
  assign flush_ifid_o  = rst_n & (redir | (state == FLUSH));
  assign kill_slot2_o  = rst_n & kill_slot2;

  // A fetch is real only in RUN without decode backpressure.
  assign fetch_valid_o = (state == RUN) & ~stall_i;

  // Fetch FSM: boot bubble, sequential fetch, and refill countdown after redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      fetch_pc_o <= RESET_PC;
      flush_cnt  <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (redir) begin
            fetch_pc_o <= target;
            flush_cnt  <= CNT_LOAD;
            state      <= FLUSH;
          end else if (!stall_i) begin
            fetch_pc_o <= fetch_pc_o + PC_W'(PC_STEP);
          end
        end
        FLUSH: begin
          if (redir) begin
            // A younger redirect restarts the bubble from its own target.
            fetch_pc_o <= target;
            flush_cnt  <= CNT_LOAD;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
            if (flush_cnt == CNT_W'(1)) begin
              state <= RUN;
            end
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // Saturating performance count of redirect cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_o <= '0;
    end else if (redir && (redirect_cnt_o != CNT_MAX)) begin
      redirect_cnt_o <= redirect_cnt_o + PERF_W'(1);
    end
  end

endmodule
